// File: rtl/alu2_result_fifo.sv
// alu2_result_fifo: first-word-fall-through FIFO for alu4_cl result words,
// with a saturating flag counter and an upstream stall-protocol checker.
module alu2_result_fifo #(
   parameter int WIDTH    = 6,
   parameter int DEPTH    = 4,
   parameter int FLAG_BIT = 3
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_par,
   input  logic                     out_ready,
   input  logic                     flush,
   input  logic                     clear,
   output logic [$clog2(DEPTH):0]   count,
   output logic [7:0]               flag_cnt,
   output logic                     err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic {IDLE, HOLD} state_t;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [WIDTH-1:0] held, held_nx;
   state_t           state, state_nx;
   logic             push, pop, viol;
   assign in_ready  = ~flush & (count < CW'(DEPTH));
   assign out_valid = count != '0;
   assign out_data  = mem[rd_ptr];
   assign out_par   = ^out_data;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready & ~flush;
   // A stalled word must be held stable until accepted or flushed.
   always_comb begin
      state_nx = state;
      held_nx  = held;
      viol     = 1'b0;
      if (state == IDLE) begin
         if (in_valid && !push) begin
            state_nx = HOLD;
            held_nx  = in_data;
         end
      end else if (push || flush) begin
         state_nx = IDLE;
      end else if (!in_valid || in_data != held) begin
         viol     = 1'b1;
         state_nx = IDLE;
      end
   end
   always_ff @(posedge clock)
      if (push) mem[wr_ptr] <= in_data;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         flag_cnt <= '0;
         err      <= 1'b0;
         state    <= IDLE;
         held     <= '0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
         flag_cnt <= clear ? 8'd0 :
                     (push && in_data[FLAG_BIT] && flag_cnt != 8'hFF) ? flag_cnt + 8'd1 : flag_cnt;
         err      <= clear ? 1'b0 : err | viol;
         state    <= state_nx;
         held     <= held_nx;
      end
endmodule

// File: tb/tb_alu2_result_fifo.sv
// tb_alu2_result_fifo: directed stimulus against a queue-based reference model,
// checked every cycle plus literal expectations at key points.
module tb_alu2_result_fifo;
   localparam int DEPTH = 4;
   logic       clock = 0, reset_n = 0;
   logic       in_valid = 0, out_ready = 0, flush = 0, clear = 0;
   logic [5:0] in_data = 0;
   logic       in_ready, out_valid, out_par, err;
   logic [5:0] out_data;
   logic [2:0] count;
   logic [7:0] flag_cnt;
   int tests = 0, fails = 0;
   logic [5:0] q[$];
   int         m_flag = 0;
   bit         m_err = 0, m_stall = 0;
   logic [5:0] m_word = 0;

   alu2_result_fifo dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_par(out_par),
      .out_ready(out_ready), .flush(flush), .clear(clear), .count(count),
      .flag_cnt(flag_cnt), .err(err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_flag = 0;
      m_err = 0;
      m_stall = 0;
   endtask

   // Applies one clock edge of the specified behaviour to the reference model.
   task automatic model_step();
      bit push, pop, viol;
      if (!reset_n) begin
         model_reset();
         return;
      end
      push = in_valid && !flush && q.size() < DEPTH;
      pop  = q.size() != 0 && out_ready && !flush;
      viol = 0;
      if (m_stall) begin
         if (!(push || flush)) viol = !in_valid || in_data != m_word;
         m_stall = !(push || flush || viol);
      end else if (in_valid && !push) begin
         m_stall = 1;
         m_word = in_data;
      end
      if (clear) m_flag = 0;
      else if (push && in_data[3] && m_flag < 255) m_flag++;
      if (clear) m_err = 0;
      else if (viol) m_err = 1;
      if (flush) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(in_data);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic push_word(input logic [5:0] d);
      in_valid = 1;
      in_data = d;
      tick();
   endtask

   always @(negedge clock) begin
      chk("count", count, q.size());
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, !flush && q.size() < DEPTH);
      chk("flag_cnt", flag_cnt, m_flag);
      chk("err", err, m_err);
      if (q.size() != 0) begin
         chk("out_data", out_data, q[0]);
         chk("out_par", out_par, ^q[0]);
      end
   end

   initial begin
      tick();
      tick();
      reset_n = 1;
      tick();
      chk("rst_count", count, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_flag", flag_cnt, 0);
      chk("rst_err", err, 0);
      // fill then drain
      for (int i = 1; i <= 4; i++) push_word(6'(i));
      in_valid = 0;
      #1;
      chk("full_count", count, 4);
      chk("full_in_ready", in_ready, 0);
      out_ready = 1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_data", out_data, i);
         tick();
      end
      chk("drained_count", count, 0);
      // concurrent traffic across pointer wrap
      for (int i = 0; i < 10; i++) begin
         push_word(6'(i));
         chk("wrap_data", out_data, i);
         chk("wrap_count", count, 1);
      end
      in_valid = 0;
      tick();
      chk("wrap_empty", count, 0);
      chk("wrap_flag", flag_cnt, 2);
      // parity
      out_ready = 0;
      push_word(6'h07);
      in_valid = 0;
      chk("par_07", out_par, 1);
      out_ready = 1;
      tick();
      out_ready = 0;
      push_word(6'h3F);
      in_valid = 0;
      chk("par_3f", out_par, 0);
      out_ready = 1;
      tick();
      // flag saturation, then clear beats a counted push
      in_valid = 1;
      in_data = 6'h08;
      repeat (300) tick();
      chk("flag_sat", flag_cnt, 255);
      clear = 1;
      tick();
      clear = 0;
      chk("flag_clear", flag_cnt, 0);
      in_valid = 0;
      tick();
      // protocol violation while stalled
      out_ready = 0;
      for (int i = 0; i < 4; i++) push_word(6'(8'h10 + i));
      in_data = 6'h2A;
      tick();
      tick();
      chk("stall_no_err", err, 0);
      in_data = 6'h15;
      tick();
      chk("viol_err", err, 1);
      tick();
      chk("err_sticky", err, 1);
      in_valid = 0;
      clear = 1;
      tick();
      clear = 0;
      chk("err_clear", err, 0);
      out_ready = 1;
      repeat (4) tick();
      chk("viol_drained", count, 0);
      // flush mid-stream
      out_ready = 0;
      push_word(6'h21);
      push_word(6'h22);
      push_word(6'h23);
      in_data = 6'h24;
      out_ready = 1;
      flush = 1;
      #1;
      chk("flush_in_ready", in_ready, 0);
      tick();
      flush = 0;
      chk("flush_count", count, 0);
      chk("flush_out_valid", out_valid, 0);
      tick();
      chk("post_flush_data", out_data, 6'h24);
      chk("post_flush_count", count, 1);
      in_valid = 0;
      tick();
      chk("post_flush_empty", count, 0);
      // asynchronous reset mid-stream
      out_ready = 0;
      push_word(6'h31);
      push_word(6'h38);
      push_word(6'h33);
      in_valid = 0;
      chk("pre_rst_count", count, 3);
      chk("pre_rst_flag", flag_cnt, 1);
      #2;
      reset_n = 0;
      model_reset();
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_count", count, 0);
      chk("async_flag", flag_cnt, 0);
      chk("async_in_ready", in_ready, 1);
      tick();
      reset_n = 1;
      tick();
      chk("post_rst_out_valid", out_valid, 0);
      push_word(6'h05);
      in_valid = 0;
      chk("post_rst_data", out_data, 6'h05);
      chk("post_rst_count", count, 1);
      out_ready = 1;
      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
